// File: rtl/pdt_tournament_pkg.sv
// rtl/pdt_tournament_pkg.sv - shared constants, types and helpers for the tournament predictor
package pdt_tournament_pkg;

    // Default geometry
    localparam int DEF_ADDR_W      = 32;
    localparam int DEF_GHR_W       = 10;
    localparam int DEF_LOCAL_IDX_W = 8;
    localparam int DEF_BTB_IDX_W   = 4;

    // 2-bit saturating counter values
    localparam logic [1:0] CNT_SNT = 2'b00;
    localparam logic [1:0] CNT_WNT = 2'b01;
    localparam logic [1:0] CNT_WT  = 2'b10;
    localparam logic [1:0] CNT_ST  = 2'b11;

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } pdt_state_e;

    // One saturating step toward taken (inc=1) or not-taken (inc=0)
    function automatic logic [1:0] sat_step(input logic [1:0] cnt, input logic inc);
        if (inc) begin
            return (cnt == CNT_ST) ? CNT_ST : cnt + 2'd1;
        end
        return (cnt == CNT_SNT) ? CNT_SNT : cnt - 2'd1;
    endfunction

endpackage

// File: rtl/pdt_tournament_if.sv
// rtl/pdt_tournament_if.sv - lookup and training signals between pipeline and predictor
// master: IF/ID pipeline side (drives fetch PC and resolution, consumes prediction)
// slave : predictor side
interface pdt_tournament_if
    import pdt_tournament_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int GHR_W  = DEF_GHR_W
);
    // IF-stage lookup
    logic              stall_i;
    logic              if_valid_i;
    logic [ADDR_W-1:0] if_pc_i;
    logic              pred_taken_o;
    logic [ADDR_W-1:0] pred_target_o;
    logic [1:0]        pred_comp_o;
    logic [GHR_W-1:0]  pred_ghr_o;
    logic              ready_o;

    // ID-stage resolution
    logic              upd_valid_i;
    logic [ADDR_W-1:0] upd_pc_i;
    logic              upd_taken_i;
    logic [ADDR_W-1:0] upd_target_i;
    logic [1:0]        upd_comp_i;
    logic [GHR_W-1:0]  upd_ghr_i;
    logic              upd_mispredict_i;

    modport master (
        output stall_i, if_valid_i, if_pc_i,
        output upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i,
        output upd_comp_i, upd_ghr_i, upd_mispredict_i,
        input  pred_taken_o, pred_target_o, pred_comp_o, pred_ghr_o, ready_o
    );

    modport slave (
        input  stall_i, if_valid_i, if_pc_i,
        input  upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i,
        input  upd_comp_i, upd_ghr_i, upd_mispredict_i,
        output pred_taken_o, pred_target_o, pred_comp_o, pred_ghr_o, ready_o
    );

endinterface

// File: rtl/pdt_tournament_sat_cnt_table.sv
// rtl/pdt_tournament_sat_cnt_table.sv - table of 2-bit saturating counters
// clk     : clock
// rd_idx  : combinational read index, rd_cnt : counter at rd_idx
// wr_en   : train entry wr_idx one step toward taken (wr_inc=1) or not-taken
// clr_en  : sweep-clear entry clr_idx to weakly-not-taken; indices past the
//           table depth are ignored so one sweep counter can serve all tables
module pdt_tournament_sat_cnt_table
    import pdt_tournament_pkg::*;
#(
    parameter int IDX_W = DEF_LOCAL_IDX_W,
    parameter int CLR_W = IDX_W
) (
    input  logic             clk,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [1:0]       rd_cnt,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_inc,
    input  logic             clr_en,
    input  logic [CLR_W-1:0] clr_idx
);

    localparam int DEPTH = 1 << IDX_W;

    logic [1:0] mem [DEPTH];
    logic       clr_hit;

    assign clr_hit = clr_en && ((clr_idx >> IDX_W) == '0);

    // No reset on the array: the post-reset sweep initialises it
    always_ff @(posedge clk) begin
        if (clr_hit) begin
            mem[clr_idx[IDX_W-1:0]] <= CNT_WNT;
        end else if (wr_en) begin
            mem[wr_idx] <= sat_step(mem[wr_idx], wr_inc);
        end
    end

    // Read returns the pre-update value when it collides with a write
    assign rd_cnt = mem[rd_idx];

endmodule

// File: rtl/pdt_tournament.sv
// rtl/pdt_tournament.sv - tournament branch predictor (local + gshare + chooser + BTB)
// clk : core clock
// rst : asynchronous active-low reset
// bus : pdt_tournament_if.slave - IF lookup (0-cycle) and ID training (visible next cycle)
module pdt_tournament
    import pdt_tournament_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int GHR_W       = DEF_GHR_W,
    parameter int LOCAL_IDX_W = DEF_LOCAL_IDX_W,
    parameter int BTB_IDX_W   = DEF_BTB_IDX_W
) (
    input logic             clk,
    input logic             rst,
    pdt_tournament_if.slave bus
);

    localparam int SWEEP_W = (GHR_W > LOCAL_IDX_W) ? GHR_W : LOCAL_IDX_W;
    localparam int BTB_N   = 1 << BTB_IDX_W;
    localparam int TAG_W   = ADDR_W - BTB_IDX_W - 2;

    // ---------------- control FSM and sweep counter ----------------
    pdt_state_e         state;
    logic [SWEEP_W-1:0] sweep_cnt;
    logic               ready_q;
    logic               sweep_en;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_INIT;
            sweep_cnt <= '0;
            ready_q   <= 1'b0;
        end else begin
            case (state)
                S_INIT: begin
                    sweep_cnt <= sweep_cnt + 1'b1;
                    if (sweep_cnt == '1) begin
                        state   <= S_RUN;
                        ready_q <= 1'b1;
                    end
                end
                S_RUN: begin
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign sweep_en = (state == S_INIT);

    // ---------------- global history ----------------
    logic [GHR_W-1:0] ghr;

    // ---------------- lookup indexing ----------------
    logic [LOCAL_IDX_W-1:0] loc_idx;
    logic [GHR_W-1:0]       glb_idx;
    logic [BTB_IDX_W-1:0]   btb_idx;
    logic [TAG_W-1:0]       btb_tag_in;

    assign loc_idx    = bus.if_pc_i[LOCAL_IDX_W+1:2];
    assign glb_idx    = bus.if_pc_i[GHR_W+1:2] ^ ghr;
    assign btb_idx    = bus.if_pc_i[BTB_IDX_W+1:2];
    assign btb_tag_in = bus.if_pc_i[ADDR_W-1:BTB_IDX_W+2];

    // ---------------- training indexing ----------------
    logic [LOCAL_IDX_W-1:0] upd_loc_idx;
    logic [GHR_W-1:0]       upd_glb_idx;
    logic [BTB_IDX_W-1:0]   upd_btb_idx;
    logic                   train_en;
    logic                   cho_wr_en;
    logic                   cho_inc;

    assign upd_loc_idx = bus.upd_pc_i[LOCAL_IDX_W+1:2];
    assign upd_glb_idx = bus.upd_pc_i[GHR_W+1:2] ^ bus.upd_ghr_i;
    assign upd_btb_idx = bus.upd_pc_i[BTB_IDX_W+1:2];
    assign train_en    = ready_q && bus.upd_valid_i;
    // Chooser only learns when the two components disagreed; move toward
    // global when global was right, toward local otherwise.
    assign cho_wr_en   = train_en && (bus.upd_comp_i[1] != bus.upd_comp_i[0]);
    assign cho_inc     = (bus.upd_comp_i[1] == bus.upd_taken_i);

    // ---------------- counter tables ----------------
    logic [1:0] loc_cnt, glb_cnt, cho_cnt;

    pdt_tournament_sat_cnt_table #(.IDX_W(LOCAL_IDX_W), .CLR_W(SWEEP_W)) u_local (
        .clk     (clk),
        .rd_idx  (loc_idx),
        .rd_cnt  (loc_cnt),
        .wr_en   (train_en),
        .wr_idx  (upd_loc_idx),
        .wr_inc  (bus.upd_taken_i),
        .clr_en  (sweep_en),
        .clr_idx (sweep_cnt)
    );

    pdt_tournament_sat_cnt_table #(.IDX_W(GHR_W), .CLR_W(SWEEP_W)) u_global (
        .clk     (clk),
        .rd_idx  (glb_idx),
        .rd_cnt  (glb_cnt),
        .wr_en   (train_en),
        .wr_idx  (upd_glb_idx),
        .wr_inc  (bus.upd_taken_i),
        .clr_en  (sweep_en),
        .clr_idx (sweep_cnt)
    );

    pdt_tournament_sat_cnt_table #(.IDX_W(LOCAL_IDX_W), .CLR_W(SWEEP_W)) u_chooser (
        .clk     (clk),
        .rd_idx  (loc_idx),
        .rd_cnt  (cho_cnt),
        .wr_en   (cho_wr_en),
        .wr_idx  (upd_loc_idx),
        .wr_inc  (cho_inc),
        .clr_en  (sweep_en),
        .clr_idx (sweep_cnt)
    );

    // ---------------- BTB (direct mapped) ----------------
    logic [BTB_N-1:0]  btb_valid;
    logic [TAG_W-1:0]  btb_tag    [BTB_N];
    logic [ADDR_W-1:0] btb_target [BTB_N];
    logic              btb_wr;
    logic              btb_hit;

    // Only taken branches allocate; a conflicting entry is simply overwritten
    assign btb_wr  = train_en && bus.upd_taken_i;
    assign btb_hit = btb_valid[btb_idx] && (btb_tag[btb_idx] == btb_tag_in);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btb_valid <= '0;
        end else if (btb_wr) begin
            btb_valid[upd_btb_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (btb_wr) begin
            btb_tag[upd_btb_idx]    <= bus.upd_pc_i[ADDR_W-1:BTB_IDX_W+2];
            btb_target[upd_btb_idx] <= bus.upd_target_i;
        end
    end

    // ---------------- prediction ----------------
    logic local_pred, global_pred, sel_pred, pred_taken;

    assign local_pred  = loc_cnt[1];
    assign global_pred = glb_cnt[1];
    assign sel_pred    = cho_cnt[1] ? global_pred : local_pred;
    assign pred_taken  = ready_q && bus.if_valid_i && btb_hit && sel_pred;

    // Speculative history: shift on every non-stalled BTB-hit fetch; a
    // mispredict repair from ID wins over the same-cycle speculative shift.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ghr <= '0;
        end else if (ready_q) begin
            if (bus.upd_valid_i && bus.upd_mispredict_i) begin
                ghr <= {bus.upd_ghr_i[GHR_W-2:0], bus.upd_taken_i};
            end else if (bus.if_valid_i && !bus.stall_i && btb_hit) begin
                ghr <= {ghr[GHR_W-2:0], pred_taken};
            end
        end
    end

    assign bus.pred_taken_o  = pred_taken;
    assign bus.pred_target_o = pred_taken ? btb_target[btb_idx] : bus.if_pc_i + ADDR_W'(4);
    assign bus.pred_comp_o   = {global_pred, local_pred};
    assign bus.pred_ghr_o    = ghr;
    assign bus.ready_o       = ready_q;

    // Word-aligned PCs: the byte-offset bits never index anything
    logic unused_pc_bits;
    assign unused_pc_bits = &{1'b0, bus.if_pc_i[1:0], bus.upd_pc_i[1:0]};

endmodule

// File: tb/tb_pdt_tournament.sv
// tb/tb_pdt_tournament.sv - self-checking bench for pdt_tournament
module tb_pdt_tournament;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pdt_tournament_if #(.ADDR_W(32), .GHR_W(10)) bus ();

    pdt_tournament #(
        .ADDR_W(32), .GHR_W(10), .LOCAL_IDX_W(8), .BTB_IDX_W(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // ---------------- reference model ----------------
    int          m_loc [256];
    int          m_glb [1024];
    int          m_cho [256];
    bit          m_bv  [16];
    logic [31:0] m_btag[16];
    logic [31:0] m_btgt[16];
    int          m_ghr;
    bit          m_ready;
    int          m_left;

    // values sampled from the DUT in the last tick
    logic        s_taken, s_ready;
    logic [31:0] s_target;
    logic [9:0]  s_ghr;
    logic [1:0]  s_comp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic int sat(input int c, input bit inc);
        if (inc) return (c == 3) ? 3 : c + 1;
        return (c == 0) ? 0 : c - 1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 256; i++) begin m_loc[i] = 1; m_cho[i] = 1; end
        for (int i = 0; i < 1024; i++) m_glb[i] = 1;
        for (int i = 0; i < 16; i++) m_bv[i] = 0;
        m_ghr   = 0;
        m_ready = 0;
        m_left  = 1024;
    endtask

    task automatic model_predict(input logic [31:0] pc, input bit valid,
                                 output bit pt, output logic [31:0] tgt,
                                 output logic [1:0] comp, output bit hit);
        int li, gi, bi;
        bit lp, gp, sel;
        li  = int'((pc >> 2) % 256);
        gi  = int'((pc >> 2) % 1024) ^ m_ghr;
        bi  = int'((pc >> 2) % 16);
        hit = m_bv[bi] && (m_btag[bi] == (pc >> 6));
        lp  = (m_loc[li] >= 2);
        gp  = (m_glb[gi] >= 2);
        sel = (m_cho[li] >= 2) ? gp : lp;
        pt  = m_ready && valid && hit && sel;
        tgt = pt ? m_btgt[bi] : pc + 32'd4;
        comp = {gp, lp};
    endtask

    task automatic model_update(input bit pt, input bit hit);
        int li, gi, bi;
        if (!m_ready) begin
            m_left--;
            if (m_left == 0) m_ready = 1;
            return;
        end
        if (bus.upd_valid_i && bus.upd_mispredict_i)
            m_ghr = ((int'(bus.upd_ghr_i) << 1) | int'(bus.upd_taken_i)) % 1024;
        else if (bus.if_valid_i && !bus.stall_i && hit)
            m_ghr = ((m_ghr << 1) | int'(pt)) % 1024;
        if (bus.upd_valid_i) begin
            li = int'((bus.upd_pc_i >> 2) % 256);
            gi = int'((bus.upd_pc_i >> 2) % 1024) ^ int'(bus.upd_ghr_i);
            bi = int'((bus.upd_pc_i >> 2) % 16);
            m_loc[li] = sat(m_loc[li], bus.upd_taken_i);
            m_glb[gi] = sat(m_glb[gi], bus.upd_taken_i);
            if (bus.upd_comp_i[1] != bus.upd_comp_i[0])
                m_cho[li] = sat(m_cho[li], bus.upd_comp_i[1] == bus.upd_taken_i);
            if (bus.upd_taken_i) begin
                m_bv[bi]   = 1;
                m_btag[bi] = bus.upd_pc_i >> 6;
                m_btgt[bi] = bus.upd_target_i;
            end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic set_idle();
        bus.stall_i          = 1'b0;
        bus.if_valid_i       = 1'b0;
        bus.if_pc_i          = 32'h0;
        bus.upd_valid_i      = 1'b0;
        bus.upd_pc_i         = 32'h0;
        bus.upd_taken_i      = 1'b0;
        bus.upd_target_i     = 32'h0;
        bus.upd_comp_i       = 2'b00;
        bus.upd_ghr_i        = 10'h0;
        bus.upd_mispredict_i = 1'b0;
    endtask

    task automatic drive_upd(input logic [31:0] pc, input bit taken, input logic [31:0] tgt,
                             input logic [9:0] ghr, input bit mis);
        bus.upd_valid_i      = 1'b1;
        bus.upd_pc_i         = pc;
        bus.upd_taken_i      = taken;
        bus.upd_target_i     = tgt;
        bus.upd_comp_i       = 2'b00;
        bus.upd_ghr_i        = ghr;
        bus.upd_mispredict_i = mis;
    endtask

    // Called at a negedge with inputs set: sample, check against model, advance one clock.
    task automatic tick();
        bit pt, hit;
        logic [31:0] tg;
        logic [1:0] cp;
        #1;
        s_taken  = bus.pred_taken_o;
        s_target = bus.pred_target_o;
        s_ghr    = bus.pred_ghr_o;
        s_comp   = bus.pred_comp_o;
        s_ready  = bus.ready_o;
        model_predict(bus.if_pc_i, bus.if_valid_i, pt, tg, cp, hit);
        chk("ready", {31'b0, s_ready}, {31'b0, m_ready});
        chk("pred_taken", {31'b0, s_taken}, {31'b0, pt});
        chk("pred_target", s_target, tg);
        if (m_ready) begin
            chk("pred_comp", {30'b0, s_comp}, {30'b0, cp});
            chk("pred_ghr", {22'b0, s_ghr}, m_ghr);
        end
        model_update(pt, hit);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        set_idle();
        bus.if_valid_i = 1'b1;
        bus.if_pc_i    = 32'h1100;
        rst = 1'b0;
        model_reset();
        #1;
        chk("rst_ready", {31'b0, bus.ready_o}, 0);
        chk("rst_taken", {31'b0, bus.pred_taken_o}, 0);
        chk("rst_target", bus.pred_target_o, 32'h1104);
        chk("rst_ghr", {22'b0, bus.pred_ghr_o}, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic sweep_check(input string tag);
        int zeros;
        bit seen_one;
        zeros = 0;
        seen_one = 0;
        for (int i = 0; i < 1100; i++) begin
            set_idle();
            bus.if_valid_i = 1'b1;
            bus.if_pc_i    = $urandom & 32'hFFFF_FFFC;
            tick();
            if (!s_ready && !seen_one) zeros++;
            else seen_one = 1;
        end
        chk({tag, "_ready_low_cycles"}, zeros, 1024);
        chk({tag, "_ready_final"}, {31'b0, s_ready}, 1);
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] base;
        base = 32'($urandom_range(0, 63)) << 2;
        return base + ($urandom_range(0, 1) != 0 ? 32'h1000 : 32'h0);
    endfunction

    // ---------------- directed vectors ----------------
    typedef struct {
        bit          is_upd;
        logic [31:0] pc;
        bit          taken;
        logic [31:0] tgt;
        bit          exp_taken;
        logic [31:0] exp_tgt;
        string       name;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input bit u, input logic [31:0] pc, input bit t,
                                input logic [31:0] tg, input bit et,
                                input logic [31:0] etg, input string n);
        vec_t v;
        v.is_upd = u; v.pc = pc; v.taken = t; v.tgt = tg;
        v.exp_taken = et; v.exp_tgt = etg; v.name = n;
        vecs.push_back(v);
    endfunction

    initial begin
        add(1, 32'h100,  1, 32'h200, 0, 0, "train1");
        add(1, 32'h100,  1, 32'h200, 0, 0, "train2");
        add(0, 32'h100,  0, 0, 1, 32'h200, "lookup_trained");
        add(1, 32'h100,  1, 32'h200, 0, 0, "sat1");
        add(1, 32'h100,  1, 32'h200, 0, 0, "sat2");
        add(1, 32'h100,  1, 32'h200, 0, 0, "sat3");
        add(0, 32'h100,  0, 0, 1, 32'h200, "lookup_sat");
        add(1, 32'h100,  0, 0, 0, 0, "nt1");
        add(0, 32'h100,  0, 0, 1, 32'h200, "lookup_after_nt1");
        add(1, 32'h100,  0, 0, 0, 0, "nt2");
        add(0, 32'h100,  0, 0, 0, 32'h104, "lookup_after_nt2");
        add(1, 32'h100,  0, 0, 0, 0, "nt3");
        add(0, 32'h100,  0, 0, 0, 32'h104, "lookup_floor");
        add(1, 32'h100,  1, 32'h200, 0, 0, "retrain1");
        add(1, 32'h100,  1, 32'h200, 0, 0, "retrain2");
        add(1, 32'h100,  1, 32'h200, 0, 0, "retrain3");
        add(0, 32'h100,  0, 0, 1, 32'h200, "lookup_retrained");
        add(1, 32'h1100, 1, 32'h300, 0, 0, "conflict_upd");
        add(0, 32'h100,  0, 0, 0, 32'h104, "lookup_evicted");
        add(0, 32'h1100, 0, 0, 1, 32'h300, "lookup_conflict");

        #2;
        do_reset();
        sweep_check("sweep");

        // training / saturation / BTB conflict
        foreach (vecs[i]) begin
            set_idle();
            if (vecs[i].is_upd) begin
                drive_upd(vecs[i].pc, vecs[i].taken, vecs[i].tgt, 10'h0, 1'b0);
            end else begin
                bus.if_valid_i = 1'b1;
                bus.if_pc_i    = vecs[i].pc;
            end
            tick();
            if (!vecs[i].is_upd) begin
                chk({vecs[i].name, "_taken"}, {31'b0, s_taken}, {31'b0, vecs[i].exp_taken});
                chk({vecs[i].name, "_target"}, s_target, vecs[i].exp_tgt);
            end
        end

        // GHR repair: force 0x3FF, then repair to 0x155/not-taken during a hit fetch
        set_idle();
        drive_upd(32'h2004, 1'b1, 32'h3000, 10'h1FF, 1'b1);
        tick();
        set_idle();
        bus.if_valid_i = 1'b1;
        bus.if_pc_i    = 32'h1100;
        drive_upd(32'h2008, 1'b0, 32'h0, 10'h155, 1'b1);
        tick();
        chk("repair_ghr_before", {22'b0, s_ghr}, 32'h3FF);
        chk("repair_fetch_taken", {31'b0, s_taken}, 1);

        // stall freezes history across repeated hit fetches
        for (int i = 0; i < 4; i++) begin
            set_idle();
            bus.stall_i    = 1'b1;
            bus.if_valid_i = 1'b1;
            bus.if_pc_i    = 32'h1100;
            tick();
            chk("stall_ghr", {22'b0, s_ghr}, 32'h2AA);
        end
        set_idle();
        bus.if_valid_i = 1'b1;
        bus.if_pc_i    = 32'h1100;
        tick();
        chk("unstall_ghr", {22'b0, s_ghr}, 32'h2AA);
        set_idle();
        tick();
        chk("shift_ghr", {22'b0, s_ghr}, 32'h155);

        // reset in the middle of a sweep restarts it from scratch
        do_reset();
        for (int i = 0; i < 500; i++) begin
            set_idle();
            bus.if_valid_i = 1'b1;
            bus.if_pc_i    = rand_pc();
            tick();
        end
        do_reset();
        sweep_check("resweep");

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            set_idle();
            bus.if_valid_i = ($urandom_range(0, 3) != 0);
            bus.stall_i    = ($urandom_range(0, 4) == 0);
            bus.if_pc_i    = rand_pc();
            if ($urandom_range(0, 1) != 0) begin
                bus.upd_valid_i      = 1'b1;
                bus.upd_pc_i         = rand_pc();
                bus.upd_taken_i      = 1'($urandom_range(0, 1));
                bus.upd_target_i     = $urandom & 32'hFFFF_FFFC;
                bus.upd_comp_i       = 2'($urandom_range(0, 3));
                bus.upd_ghr_i        = 10'($urandom_range(0, 1023));
                bus.upd_mispredict_i = ($urandom_range(0, 3) == 0);
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
